// File: rtl/cpu_defines.sv
`default_nettype none
// ============================================================================
// cpu_defines -- shared MEM-stage encodings: memory ops, FSM states, lanes.
// Rev 1.0
// ============================================================================
package cpu_defines;

    localparam logic [3:0] MEM_OP_NONE = 4'd0;
    localparam logic [3:0] MEM_OP_LB   = 4'd1;
    localparam logic [3:0] MEM_OP_LBU  = 4'd2;
    localparam logic [3:0] MEM_OP_LH   = 4'd3;
    localparam logic [3:0] MEM_OP_LHU  = 4'd4;
    localparam logic [3:0] MEM_OP_LW   = 4'd5;
    localparam logic [3:0] MEM_OP_SB   = 4'd6;
    localparam logic [3:0] MEM_OP_SH   = 4'd7;
    localparam logic [3:0] MEM_OP_SW   = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    function automatic logic op_is_load(input logic [3:0] op);
        return (op >= MEM_OP_LB) && (op <= MEM_OP_LW);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op >= MEM_OP_SB) && (op <= MEM_OP_SW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_load_extract.sv
`default_nettype none
// ============================================================================
// mem_load_extract -- byte/halfword lane select with sign or zero extension.
// Rev 1.0
// ============================================================================
module mem_load_extract
    import cpu_defines::*;
(
    input  logic [3:0]  operation,
    input  logic [1:0]  addr_low,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word[7:0];
        case (addr_low)
            2'd0: w_byte = word[7:0];
            2'd1: w_byte = word[15:8];
            2'd2: w_byte = word[23:16];
            2'd3: w_byte = word[31:24];
            default: w_byte = word[7:0];
        endcase
        w_half = addr_low[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data = word;
        case (operation)
            MEM_OP_LB:  data = {{24{w_byte[7]}}, w_byte};
            MEM_OP_LBU: data = {24'd0, w_byte};
            MEM_OP_LH:  data = {{16{w_half[15]}}, w_half};
            MEM_OP_LHU: data = {16'd0, w_half};
            default:    data = word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/stage_mem.sv
`default_nettype none
// ============================================================================
// stage_mem -- MIPS memory-access stage: bus handshake, stall and WB triple.
// Rev 1.0
// ============================================================================
module stage_mem
    import cpu_defines::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_register_write_enable,
    input  logic [4:0]  mem_register_write_address,
    input  logic [31:0] mem_register_write_data,
    input  logic [3:0]  mem_operation,
    input  logic [31:0] mem_store_data,
    output logic        wb_register_write_enable,
    output logic [4:0]  wb_register_write_address,
    output logic [31:0] wb_register_write_data,
    output logic        stall_request,
    output logic        address_error,
    output logic        bus_error,
    output logic        bus_request,
    output logic        bus_write,
    output logic [31:0] bus_address,
    output logic [3:0]  bus_byte_enable,
    output logic [31:0] bus_write_data,
    input  logic        bus_ready,
    input  logic [31:0] bus_read_data
);

    localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    mem_state_t  r_state;
    logic        r_bus_request;
    logic        r_bus_write;
    logic [31:0] r_bus_address;
    logic [3:0]  r_bus_byte_enable;
    logic [31:0] r_bus_write_data;
    logic [31:0] r_read_data;
    logic        r_bus_error;
    logic [15:0] r_count;

    logic [31:0] w_addr;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_mem;
    logic        w_misaligned;
    logic        w_start;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;

    assign w_addr     = mem_register_write_data;
    assign w_is_load  = op_is_load(mem_operation);
    assign w_is_store = op_is_store(mem_operation);
    assign w_is_mem   = w_is_load | w_is_store;
    assign w_start    = (r_state == ST_IDLE) && w_is_mem && !w_misaligned;

    always_comb begin
        w_misaligned = 1'b0;
        w_be         = 4'b0000;
        w_wdata      = 32'd0;
        case (mem_operation)
            MEM_OP_LB, MEM_OP_LBU: begin
                w_be = BE_BYTE0 << w_addr[1:0];
            end
            MEM_OP_SB: begin
                w_be    = BE_BYTE0 << w_addr[1:0];
                w_wdata = {4{mem_store_data[7:0]}};
            end
            MEM_OP_LH, MEM_OP_LHU: begin
                w_misaligned = w_addr[0];
                w_be         = w_addr[1] ? BE_HALF_HI : BE_HALF_LO;
            end
            MEM_OP_SH: begin
                w_misaligned = w_addr[0];
                w_be         = w_addr[1] ? BE_HALF_HI : BE_HALF_LO;
                w_wdata      = {2{mem_store_data[15:0]}};
            end
            MEM_OP_LW: begin
                w_misaligned = (w_addr[1:0] != 2'b00);
                w_be         = BE_WORD;
            end
            MEM_OP_SW: begin
                w_misaligned = (w_addr[1:0] != 2'b00);
                w_be         = BE_WORD;
                w_wdata      = mem_store_data;
            end
            default: ;
        endcase
    end

    // EX/MEM is frozen while stalled, so DONE can extract from the live op/address.
    mem_load_extract u_extract (
        .operation (mem_operation),
        .addr_low  (w_addr[1:0]),
        .word      (r_read_data),
        .data      (w_load_data)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state           <= ST_IDLE;
            r_bus_request     <= 1'b0;
            r_bus_write       <= 1'b0;
            r_bus_address     <= 32'd0;
            r_bus_byte_enable <= 4'd0;
            r_bus_write_data  <= 32'd0;
            r_read_data       <= 32'd0;
            r_bus_error       <= 1'b0;
            r_count           <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_bus_request     <= 1'b1;
                        r_bus_write       <= w_is_store;
                        r_bus_address     <= {w_addr[31:2], 2'b00};
                        r_bus_byte_enable <= w_be;
                        r_bus_write_data  <= w_wdata;
                        r_bus_error       <= 1'b0;
                        r_count           <= 16'd0;
                        r_state           <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Ready takes priority over a timeout landing in the same cycle.
                    if (bus_ready) begin
                        r_read_data   <= bus_read_data;
                        r_bus_request <= 1'b0;
                        r_state       <= ST_DONE;
                    end else begin
                        r_count <= r_count + 16'd1;
                        if (TIMEOUT_EN && (r_count == TIMEOUT_LAST)) begin
                            r_bus_request <= 1'b0;
                            r_bus_error   <= 1'b1;
                            r_state       <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_bus_error <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        wb_register_write_enable  = mem_register_write_enable;
        wb_register_write_address = mem_register_write_address;
        wb_register_write_data    = mem_register_write_data;
        stall_request             = 1'b0;
        address_error             = 1'b0;
        bus_error                 = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_is_mem) begin
                    wb_register_write_enable = 1'b0;
                    if (w_misaligned) begin
                        address_error = 1'b1;
                    end else begin
                        stall_request = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                stall_request            = 1'b1;
                wb_register_write_enable = 1'b0;
            end
            ST_DONE: begin
                if (r_bus_error) begin
                    bus_error                = 1'b1;
                    wb_register_write_enable = 1'b0;
                end else if (w_is_load) begin
                    wb_register_write_data = w_load_data;
                end
            end
            default: ;
        endcase
    end

    assign bus_request     = r_bus_request;
    assign bus_write       = r_bus_write;
    assign bus_address     = r_bus_address;
    assign bus_byte_enable = r_bus_byte_enable;
    assign bus_write_data  = r_bus_write_data;

endmodule
`default_nettype wire

// File: tb/tb_stage_mem.sv
`default_nettype none
// ============================================================================
// tb_stage_mem -- vector table plus scoreboard for the MEM stage.
// Rev 1.0
// ============================================================================
module tb_stage_mem;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_register_write_enable;
    logic [4:0]  mem_register_write_address;
    logic [31:0] mem_register_write_data;
    logic [3:0]  mem_operation;
    logic [31:0] mem_store_data;
    logic        wb_register_write_enable;
    logic [4:0]  wb_register_write_address;
    logic [31:0] wb_register_write_data;
    logic        stall_request;
    logic        address_error;
    logic        bus_error;
    logic        bus_request;
    logic        bus_write;
    logic [31:0] bus_address;
    logic [3:0]  bus_byte_enable;
    logic [31:0] bus_write_data;
    logic        bus_ready;
    logic [31:0] bus_read_data;

    int checks = 0;
    int errors = 0;

    stage_mem #(.TIMEOUT_CYCLES(4)) dut (
        .clock                      (clock),
        .reset                      (reset),
        .mem_register_write_enable  (mem_register_write_enable),
        .mem_register_write_address (mem_register_write_address),
        .mem_register_write_data    (mem_register_write_data),
        .mem_operation              (mem_operation),
        .mem_store_data             (mem_store_data),
        .wb_register_write_enable   (wb_register_write_enable),
        .wb_register_write_address  (wb_register_write_address),
        .wb_register_write_data     (wb_register_write_data),
        .stall_request              (stall_request),
        .address_error              (address_error),
        .bus_error                  (bus_error),
        .bus_request                (bus_request),
        .bus_write                  (bus_write),
        .bus_address                (bus_address),
        .bus_byte_enable            (bus_byte_enable),
        .bus_write_data             (bus_write_data),
        .bus_ready                  (bus_ready),
        .bus_read_data              (bus_read_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic        wen;
        logic [4:0]  waddr;
        int          waits;   // -1: never ready
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] bwdata;
        logic        xen;
        logic [31:0] xdata;
        logic        xerr;
        int          xstalls;
    } vec_t;

    typedef struct {
        logic        en;
        logic [4:0]  waddr;
        logic [31:0] data;
        logic        err;
        int          stalls;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [3:0] op, input logic [31:0] addr,
                                 input logic [31:0] sdata, input logic wen,
                                 input logic [4:0] waddr, input int waits,
                                 input logic [31:0] rdata, input logic [3:0] be,
                                 input logic [31:0] bwdata, input logic xen,
                                 input logic [31:0] xdata, input logic xerr,
                                 input int xstalls);
        vec_t v;
        v.op = op; v.addr = addr; v.sdata = sdata; v.wen = wen; v.waddr = waddr;
        v.waits = waits; v.rdata = rdata; v.be = be; v.bwdata = bwdata;
        v.xen = xen; v.xdata = xdata; v.xerr = xerr; v.xstalls = xstalls;
        return v;
    endfunction

    task automatic set_inputs(input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] sdata, input logic wen, input logic [4:0] waddr);
        mem_operation              = op;
        mem_register_write_data    = addr;
        mem_store_data             = sdata;
        mem_register_write_enable  = wen;
        mem_register_write_address = waddr;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        exp_t e;
        exp_t got;
        int   stalls = 0;
        int   busy = 0;
        bit   done = 0;
        bit   is_store;
        string tag;
        is_store = (v.op >= 4'd6) && (v.op <= 4'd8);
        tag = $sformatf("v%0d", idx);
        @(negedge clock);
        set_inputs(v.op, v.addr, v.sdata, v.wen, v.waddr);
        bus_ready = 1'b0;
        e.en = v.xen; e.waddr = v.waddr; e.data = v.xdata; e.err = v.xerr; e.stalls = v.xstalls;
        sb.push_back(e);
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            #1;
            if (bus_request) begin
                busy++;
                if (busy == 1) begin
                    chk({tag, " bus_address"}, bus_address, {v.addr[31:2], 2'b00});
                    chk({tag, " byte_enable"}, {28'd0, bus_byte_enable}, {28'd0, v.be});
                    chk({tag, " bus_write"}, {31'd0, bus_write}, {31'd0, is_store});
                    if (is_store) chk({tag, " write_data"}, bus_write_data, v.bwdata);
                end
                chk({tag, " busy wb_en"}, {31'd0, wb_register_write_enable}, 32'd0);
                if (v.waits >= 0 && busy == v.waits + 1) begin
                    bus_ready     = 1'b1;
                    bus_read_data = v.rdata;
                end
            end
            if (stall_request) begin
                stalls++;
            end else if (stalls > 0) begin
                got = sb.pop_front();
                chk({tag, " stall cycles"}, stalls, got.stalls);
                chk({tag, " wb_en"}, {31'd0, wb_register_write_enable}, {31'd0, got.en});
                chk({tag, " wb_addr"}, {27'd0, wb_register_write_address}, {27'd0, got.waddr});
                if (!got.err) chk({tag, " wb_data"}, wb_register_write_data, got.data);
                chk({tag, " bus_error"}, {31'd0, bus_error}, {31'd0, got.err});
                chk({tag, " done bus_request"}, {31'd0, bus_request}, 32'd0);
                done = 1;
            end else begin
                chk({tag, " stall at start"}, {31'd0, stall_request}, 32'd1);
                done = 1;
                void'(sb.pop_front());
            end
            @(negedge clock);
            bus_ready     = 1'b0;
            bus_read_data = 32'hx;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s: no DONE within cycle budget", tag);
            void'(sb.pop_front());
        end
        set_inputs(4'd0, 32'd0, 32'd0, 1'b0, 5'd0);
    endtask

    initial begin
        reset = 1'b0;
        bus_ready = 1'b0;
        bus_read_data = 32'd0;
        set_inputs(4'd0, 32'd0, 32'd0, 1'b0, 5'd0);

        //                op     addr          sdata         wen  wa  waits rdata         be       bwdata        xen  xdata         xerr stalls
        vecs[0] = mkv(4'd5, 32'h100, 32'h0,        1'b1, 5'd7, 0,  32'hDEADBEEF, 4'b1111, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 2);
        vecs[1] = mkv(4'd1, 32'h103, 32'h0,        1'b1, 5'd8, 3,  32'h80123456, 4'b1000, 32'h0,        1'b1, 32'hFFFFFF80, 1'b0, 5);
        vecs[2] = mkv(4'd2, 32'h103, 32'h0,        1'b1, 5'd9, 3,  32'h80123456, 4'b1000, 32'h0,        1'b1, 32'h00000080, 1'b0, 5);
        vecs[3] = mkv(4'd7, 32'h102, 32'h1234ABCD, 1'b0, 5'd0, 0,  32'h0,        4'b1100, 32'hABCDABCD, 1'b0, 32'h00000102, 1'b0, 2);
        vecs[4] = mkv(4'd3, 32'h102, 32'h0,        1'b1, 5'd4, 0,  32'h80011234, 4'b1100, 32'h0,        1'b1, 32'hFFFF8001, 1'b0, 2);
        vecs[5] = mkv(4'd4, 32'h100, 32'h0,        1'b1, 5'd5, 1,  32'h1234F00D, 4'b0011, 32'h0,        1'b1, 32'h0000F00D, 1'b0, 3);
        vecs[6] = mkv(4'd6, 32'h101, 32'h000000A5, 1'b1, 5'd3, 0,  32'h0,        4'b0010, 32'hA5A5A5A5, 1'b1, 32'h00000101, 1'b0, 2);
        vecs[7] = mkv(4'd8, 32'h200, 32'hCAFEF00D, 1'b0, 5'd0, 1,  32'h0,        4'b1111, 32'hCAFEF00D, 1'b0, 32'h00000200, 1'b0, 3);
        vecs[8] = mkv(4'd5, 32'h300, 32'h0,        1'b1, 5'd6, -1, 32'h0,        4'b1111, 32'h0,        1'b0, 32'h0,        1'b1, 5);
        vecs[9] = mkv(4'd1, 32'h102, 32'h0,        1'b1, 5'd2, 2,  32'h007F0000, 4'b0100, 32'h0,        1'b1, 32'h0000007F, 1'b0, 4);

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset bus_request", {31'd0, bus_request}, 32'd0);
        chk("reset bus_address", bus_address, 32'd0);
        chk("reset byte_enable", {28'd0, bus_byte_enable}, 32'd0);
        chk("reset stall", {31'd0, stall_request}, 32'd0);
        chk("reset bus_error", {31'd0, bus_error}, 32'd0);
        reset = 1'b1;

        // Pass-through with op NONE, then an undefined op code behaving as NONE.
        @(negedge clock);
        set_inputs(4'd0, 32'h42, 32'h0, 1'b1, 5'd5);
        #1;
        chk("pass wb_en", {31'd0, wb_register_write_enable}, 32'd1);
        chk("pass wb_addr", {27'd0, wb_register_write_address}, 32'd5);
        chk("pass wb_data", wb_register_write_data, 32'h42);
        chk("pass stall", {31'd0, stall_request}, 32'd0);
        @(negedge clock);
        chk("pass bus_request", {31'd0, bus_request}, 32'd0);
        set_inputs(4'd12, 32'h77, 32'h0, 1'b1, 5'd11);
        #1;
        chk("badop stall", {31'd0, stall_request}, 32'd0);
        chk("badop wb_data", wb_register_write_data, 32'h77);
        @(negedge clock);
        chk("badop bus_request", {31'd0, bus_request}, 32'd0);

        // Misaligned LW.
        set_inputs(4'd5, 32'h102, 32'h0, 1'b1, 5'd5);
        #1;
        chk("misalign address_error", {31'd0, address_error}, 32'd1);
        chk("misalign stall", {31'd0, stall_request}, 32'd0);
        chk("misalign wb_en", {31'd0, wb_register_write_enable}, 32'd0);
        @(negedge clock);
        chk("misalign bus_request", {31'd0, bus_request}, 32'd0);
        set_inputs(4'd0, 32'h0, 32'h0, 1'b0, 5'd0);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Reset during the second BUSY cycle.
        @(negedge clock);
        set_inputs(4'd5, 32'h400, 32'h0, 1'b1, 5'd1);
        @(negedge clock);
        chk("rst busy1 bus_request", {31'd0, bus_request}, 32'd1);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        set_inputs(4'd0, 32'h55, 32'h0, 1'b1, 5'd9);
        #1;
        chk("rst bus_request", {31'd0, bus_request}, 32'd0);
        chk("rst stall", {31'd0, stall_request}, 32'd0);
        chk("rst wb_data", wb_register_write_data, 32'h55);
        chk("rst bus_address", bus_address, 32'd0);
        @(negedge clock);
        chk("rst idle bus_request", {31'd0, bus_request}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
